// File: rtl/lifo_pkg.sv
// lifo_pkg: shared definitions for the stack initiator.
//   OP_*       request opcodes carried on req_op
//   state_t    controller states
//   cnt_width  occupancy counter width for a given stack depth
package lifo_pkg;

    localparam logic [1:0] OP_POP   = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        ERR,
        CLR
    } state_t;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/lifo_bus_pad.sv
// lifo_bus_pad: tristate pad for the shared stack data line.
//   oe    in    drive enable; pad floats when low
//   dout  in    value driven onto the pad
//   din   out   value currently seen on the pad
//   pad   inout shared data line
module lifo_bus_pad #(
    parameter int WIDTH = 8
) (
    input  logic             oe,
    input  logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] din,
    inout  wire  [WIDTH-1:0] pad
);

    assign pad = oe ? dout : {WIDTH{1'bz}};
    assign din = pad;

endmodule

// File: rtl/lifo_driver.sv
// lifo_driver: clocked initiator for a clockless level-sensitive push/pop stack.
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/ready/op/data     command port (pop, push, clear, reserved)
//   rsp_valid/err/data          one-cycle completion, error flag, last popped word
//   count, full, empty          locally mirrored stack occupancy
//   lifo_rst/enable/push_pop    stack control lines
//   lifo_data                   shared data line, driven only while pushing
module lifo_driver
    import lifo_pkg::*;
#(
    parameter  int WIDTH         = 8,
    parameter  int DEPTH         = 12,
    parameter  int STROBE_CYCLES = 1,
    localparam int CNT_W         = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             lifo_rst,
    output logic             lifo_enable,
    output logic             lifo_push_pop,
    inout  wire  [WIDTH-1:0] lifo_data
);

    state_t           state, state_nxt;
    logic             is_push;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] bus_in;
    logic [3:0]       tick;
    logic             rst_hold;
    logic             clr_rst;
    logic             drive;
    logic             strobe_last;
    logic             accept;

    assign accept      = (state == IDLE) && req_valid;
    assign strobe_last = (tick == 4'(STROBE_CYCLES - 1));
    assign full        = (count == CNT_W'(DEPTH));
    assign empty       = (count == '0);
    assign req_ready   = (state == IDLE);
    // The stack stays in reset until the first edge after rst_n releases,
    // and again for the whole of a clear.
    assign lifo_rst    = rst_hold | clr_rst;

    lifo_bus_pad #(.WIDTH(WIDTH)) u_pad (
        .oe   (drive),
        .dout (wdata),
        .din  (bus_in),
        .pad  (lifo_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; all request checks happen here at acceptance.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) begin
                case (req_op)
                    OP_POP:   state_nxt = empty ? ERR : SETUP;
                    OP_PUSH:  state_nxt = full  ? ERR : SETUP;
                    OP_CLEAR: state_nxt = CLR;
                    default:  state_nxt = ERR;
                endcase
            end
            SETUP:   state_nxt = STROBE;
            STROBE:  state_nxt = strobe_last ? HOLD : STROBE;
            HOLD:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            CLR:     state_nxt = (tick == 4'd1) ? IDLE : CLR;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        lifo_enable   = 1'b0;
        lifo_push_pop = 1'b0;
        drive         = 1'b0;
        clr_rst       = 1'b0;
        rsp_valid     = 1'b0;
        rsp_err       = 1'b0;
        case (state)
            SETUP: begin
                lifo_push_pop = is_push;
                drive         = is_push;
            end
            STROBE: begin
                lifo_push_pop = is_push;
                drive         = is_push;
                lifo_enable   = 1'b1;
            end
            HOLD: begin
                lifo_push_pop = is_push;
                drive         = is_push;
                rsp_valid     = 1'b1;
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
            CLR: begin
                clr_rst   = 1'b1;
                rsp_valid = (tick == 4'd1);
            end
            default: ;
        endcase
    end

    // Datapath: dwell counter (restarts on every state change), request
    // latch, occupancy mirror and pop capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick     <= 4'd0;
            is_push  <= 1'b0;
            wdata    <= '0;
            count    <= '0;
            rsp_data <= '0;
            rst_hold <= 1'b1;
        end else begin
            rst_hold <= 1'b0;
            tick     <= (state_nxt != state) ? 4'd0 : tick + 4'd1;
            if (accept) begin
                is_push <= (req_op == OP_PUSH);
                wdata   <= req_data;
            end
            if (state == STROBE && strobe_last && !is_push)
                rsp_data <= bus_in;
            if (state == HOLD)
                count <= is_push ? count + CNT_W'(1) : count - CNT_W'(1);
            else if (state == CLR && tick == 4'd1)
                count <= '0;
        end
    end

endmodule

// File: tb/tb_lifo_driver.sv
module tb_lifo_driver;
    import lifo_pkg::*;

    localparam int D = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n     [2];
    logic       req_valid [2];
    logic [1:0] req_op    [2];
    logic [7:0] req_data  [2];
    logic       req_ready [2];
    logic       rsp_valid [2];
    logic       rsp_err   [2];
    logic [7:0] rsp_data  [2];
    logic [3:0] count     [2];
    logic       full      [2];
    logic       empty     [2];
    logic       lrst      [2];
    logic       len       [2];
    logic       lpp       [2];

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the stack as seen by the requester.
    logic [7:0] mdl [2][D];
    int         msz [2];
    logic [7:0] mrd [2];

    // Instance 0: one strobe cycle; instance 1: three. Each has its own
    // behavioural stack on the shared data line.
    for (genvar g = 0; g < 2; g++) begin : u
        wire  [7:0] bus;
        logic       o_ready, o_valid, o_err, o_full, o_empty, o_rst, o_en, o_pp;
        logic [7:0] o_data;
        logic [3:0] o_count;
        logic [7:0] mem [D];
        int         sp = 0;

        lifo_driver #(.WIDTH(8), .DEPTH(D), .STROBE_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .rst_n(rst_n[g]),
            .req_valid(req_valid[g]), .req_op(req_op[g]), .req_data(req_data[g]),
            .req_ready(o_ready), .rsp_valid(o_valid), .rsp_err(o_err),
            .rsp_data(o_data), .count(o_count), .full(o_full), .empty(o_empty),
            .lifo_rst(o_rst), .lifo_enable(o_en), .lifo_push_pop(o_pp),
            .lifo_data(bus)
        );

        assign req_ready[g] = o_ready;
        assign rsp_valid[g] = o_valid;
        assign rsp_err[g]   = o_err;
        assign rsp_data[g]  = o_data;
        assign count[g]     = o_count;
        assign full[g]      = o_full;
        assign empty[g]     = o_empty;
        assign lrst[g]      = o_rst;
        assign len[g]       = o_en;
        assign lpp[g]       = o_pp;

        assign bus = (o_en && !o_pp && sp > 0) ? mem[sp-1] : 8'hzz;

        always @(posedge o_en or posedge o_rst) begin
            if (o_rst) sp = 0;
            else if (o_pp && sp < D) begin
                mem[sp] = bus;
                sp++;
            end
        end
        always @(negedge o_en) if (!o_pp && !o_rst && sp > 0) sp--;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Issue one command to instance k and check everything observable
    // against the reference model.
    task automatic cmd(input int k, input logic [1:0] op, input logic [7:0] d);
        int   s = (k == 0) ? 1 : 3;
        int   lat = 0, en_n = 0, rc = 0;
        logic got = 1'b0, err = 1'b0;
        logic exp_err = 1'b0;
        int   exp_lat, exp_en = 0, exp_rc = 0;

        case (op)
            OP_POP: if (msz[k] == 0) exp_err = 1'b1;
                    else begin msz[k]--; mrd[k] = mdl[k][msz[k]]; end
            OP_PUSH: if (msz[k] == D) exp_err = 1'b1;
                     else begin mdl[k][msz[k]] = d; msz[k]++; end
            OP_CLEAR: msz[k] = 0;
            default: exp_err = 1'b1;
        endcase
        if (exp_err)              exp_lat = 1;
        else if (op == OP_CLEAR) begin exp_lat = 2; exp_rc = 2; end
        else                     begin exp_lat = 2 + s; exp_en = s; end

        @(negedge clk);
        req_valid[k] = 1'b1; req_op[k] = op; req_data[k] = d;
        chk("ready_idle", {31'd0, req_ready[k]}, 1);
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        for (int c = 1; c <= 30 && !got; c++) begin
            @(negedge clk);
            en_n += int'(len[k]);
            rc   += int'(lrst[k]);
            chk("en_rst_excl", {31'd0, len[k] & lrst[k]}, 0);
            if (c == 1) chk("ready_busy", {31'd0, req_ready[k]}, 0);
            if (rsp_valid[k]) begin got = 1'b1; lat = c; err = rsp_err[k]; end
        end
        chk("rsp_seen", {31'd0, got}, 1);
        chk("latency", lat, exp_lat);
        chk("rsp_err", {31'd0, err}, {31'd0, exp_err});
        chk("en_cycles", en_n, exp_en);
        chk("rst_cycles", rc, exp_rc);
        @(negedge clk);
        chk("count", {28'd0, count[k]}, msz[k]);
        chk("full", {31'd0, full[k]}, {31'd0, msz[k] == D});
        chk("empty", {31'd0, empty[k]}, {31'd0, msz[k] == 0});
        chk("rsp_data", {24'd0, rsp_data[k]}, {24'd0, mrd[k]});
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_op[k] = 2'b00;
            req_data[k] = 8'h00; msz[k] = 0; mrd[k] = 8'h00;
        end

        // Reset, then pop on the empty stack
        repeat (3) @(negedge clk);
        chk("rst_lifo_rst", {31'd0, lrst[0]}, 1);
        chk("rst_count", {28'd0, count[0]}, 0);
        chk("rst_empty", {31'd0, empty[0]}, 1);
        chk("rst_en", {31'd0, len[0]}, 0);
        chk("rst_rsp_valid", {31'd0, rsp_valid[0]}, 0);
        chk("rst_rsp_data", {24'd0, rsp_data[0]}, 0);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        #1 chk("rst_hold_pre_edge", {31'd0, lrst[0]}, 1);
        @(negedge clk);
        chk("rst_release", {31'd0, lrst[0]}, 0);
        cmd(0, OP_POP, 8'h00);

        // LIFO order
        cmd(0, OP_PUSH, 8'hA5);
        cmd(0, OP_PUSH, 8'h3C);
        cmd(0, OP_PUSH, 8'h7E);
        repeat (3) cmd(0, OP_POP, 8'h00);

        // Fill, overflow, pop the top
        for (int i = 1; i <= D; i++) cmd(0, OP_PUSH, 8'(i));
        chk("fill_full", {31'd0, full[0]}, 1);
        cmd(0, OP_PUSH, 8'hFF);
        cmd(0, OP_POP, 8'h00);
        chk("after_ovf_pop", {24'd0, rsp_data[0]}, 32'h0C);

        // Clear mid-fill, reserved op
        cmd(0, OP_CLEAR, 8'h00);
        for (int i = 0; i < 5; i++) cmd(0, OP_PUSH, 8'(8'h40 + i));
        cmd(0, OP_CLEAR, 8'h00);
        cmd(0, OP_POP, 8'h00);
        cmd(0, 2'b11, 8'h00);

        // Reset during the strobe of a push
        @(negedge clk);
        req_valid[0] = 1'b1; req_op[0] = OP_PUSH; req_data[0] = 8'h55;
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort_setup_en", {31'd0, len[0]}, 0);
        chk("abort_setup_pp", {31'd0, lpp[0]}, 1);
        @(posedge clk); #1;
        chk("abort_strobe_en", {31'd0, len[0]}, 1);
        rst_n[0] = 1'b0;
        #1;
        chk("abort_en", {31'd0, len[0]}, 0);
        chk("abort_pp", {31'd0, lpp[0]}, 0);
        chk("abort_lrst", {31'd0, lrst[0]}, 1);
        chk("abort_rsp", {31'd0, rsp_valid[0]}, 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid[0]}, 0);
        end
        rst_n[0] = 1'b1;
        msz[0] = 0; mrd[0] = 8'h00;
        @(negedge clk);
        chk("abort_count", {28'd0, count[0]}, 0);
        chk("abort_lrst_rel", {31'd0, lrst[0]}, 0);
        cmd(0, OP_POP, 8'h00);

        // Longer strobe
        cmd(1, OP_PUSH, 8'h9A);
        cmd(1, OP_POP, 8'h00);
        cmd(1, OP_POP, 8'h00);

        // Random traffic, biased toward pushes so both limits get hit
        for (int n = 0; n < 120; n++) begin
            int r = $urandom_range(0, 19);
            logic [1:0] op;
            if (r < 8)       op = OP_POP;
            else if (r < 18) op = OP_PUSH;
            else if (r < 19) op = OP_CLEAR;
            else             op = 2'b11;
            cmd(0, op, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lifo_driver.md
Name: lifo_driver

Overview:
- Synchronous initiator for the level-sensitive push/pop stack. It owns the stack's control lines (rst, enable, pushPop) and the shared bidirectional data line.
- Accepts push, pop and clear commands on a valid/ready request port and returns the outcome on a response port.
- Mirrors stack occupancy locally, so overflow and underflow are rejected without any bus activity.
- Sits between a clocked datapath and the clockless stack.

Parameters:
- WIDTH, 8: data word width; must equal the stack's WIDTH.
- DEPTH, 12: stack capacity in words; must equal the stack's DEPTH.
- STROBE_CYCLES, 1: clock cycles lifo_enable is held high per access; range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req_valid  in  1  command present.
- req_op  in  2  command: 00 pop, 01 push, 10 clear, 11 reserved (treated as error).
- req_data  in  WIDTH  push word.
- req_ready  out  1  high only in IDLE.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  qualifies rsp_valid: overflow, underflow or reserved op.
- rsp_data  out  WIDTH  popped word; holds its value until the next successful pop.
- count  out  CNT_W  current stack occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- lifo_rst  out  1  stack reset, active-high.
- lifo_enable  out  1  stack enable.
- lifo_push_pop  out  1  1 = push, 0 = pop.
- lifo_data  inout  WIDTH  shared data line; driven only during push phases, otherwise Z.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, count = 0, lifo_rst = 1.
  - lifo_enable = 0, lifo_push_pop = 0, bus released.
  - rsp_valid = 0, rsp_err = 0, rsp_data = 0.
  - lifo_rst deasserts on the first clk edge after rst_n rises.
- Reset mid-operation aborts the transaction immediately. No response is issued. The stack is cleared via lifo_rst, so count = 0 stays consistent.
- Handshake:
  - A command is accepted on the edge where req_valid && req_ready. req_* are sampled at that edge only.
  - req_ready is low from the cycle after acceptance until the state returns to IDLE.
- Request checks, done at acceptance:
  - push with full -> error.
  - pop with empty -> error.
  - reserved op -> error.
  - Every error goes to ERR: one cycle with rsp_valid = 1 and rsp_err = 1, no control or bus toggle, count unchanged. Then IDLE.
- Valid push or pop sequence (cycles counted from the acceptance edge = 0):
  - SETUP, cycle 1: lifo_push_pop = op (1 push, 0 pop), enable = 0. For a push, lifo_data is driven with req_data from this cycle.
  - STROBE, cycles 2 .. 1+STROBE_CYCLES: lifo_enable = 1; push_pop and drive are held. For a pop, lifo_data is captured into rsp_data on the edge that ends the last STROBE cycle.
  - HOLD, cycle 2+STROBE_CYCLES: enable = 0; push_pop and drive are held.
    - rsp_valid = 1, rsp_err = 0.
    - count updates (+1 push, -1 pop) on the edge ending HOLD.
  - Return to IDLE: bus released, lifo_push_pop returns to 0.
  - Total occupancy per push or pop: 3 + STROBE_CYCLES cycles; at the default this is 4 cycles, response in cycle 3. No back-to-back acceptance.
- Clear:
  - Goes to CLR for 2 cycles with lifo_rst = 1, enable = 0, bus released.
  - rsp_valid = 1 in the second cycle; count becomes 0 on the edge ending it. Then IDLE.
  - Clear is always accepted, never an error.
- Invariants:
  - lifo_enable and lifo_rst are never high together.
  - lifo_push_pop never changes while lifo_enable = 1.
  - Bus drive is enabled only in SETUP, STROBE or HOLD of a push.
- Width: CNT_W = clog2(DEPTH+1). count never exceeds DEPTH and never wraps.

Decomposition:
- Package lifo_pkg holds:
  - op constants OP_POP, OP_PUSH, OP_CLEAR.
  - state enum IDLE, SETUP, STROBE, HOLD, ERR, CLR.
  - a function computing CNT_W from DEPTH.
- The strobe-length counter is 4 bits, local to the FSM.
- One sub-module, lifo_bus_pad: tristate pad with output enable and an input sample path for lifo_data, parameterised by WIDTH.

Test Plan:
- Reset to pop:
  - Stimulus: rst_n low 3 cycles, release, then pop.
  - Required: lifo_rst = 1 during reset, 0 one edge after release. count = 0, empty = 1. The pop gives rsp_err = 1 with no lifo_enable pulse.
- Push/pop order:
  - Stimulus: push 0xA5, 0x3C, 0x7E, then pop three times.
  - Required: rsp_data = 0x7E, 0x3C, 0xA5; count goes 3, 2, 1, 0. Each response lands exactly 3 cycles after acceptance. The bus is Z outside push phases.
- Fill and overflow:
  - Stimulus: push 0x01..0x0C.
  - Required: full = 1, count = 12.
  - Stimulus: a 13th push 0xFF.
  - Required: rsp_err = 1, count = 12, no enable pulse. A subsequent pop returns 0x0C.
- Clear mid-fill:
  - Stimulus: push 5 words, then clear.
  - Required: lifo_rst high 2 cycles, rsp_valid in the second, count = 0. A following pop errors.
- Reset during STROBE:
  - Stimulus: assert rst_n in the STROBE cycle of push 0x55.
  - Required: enable drops immediately, no rsp_valid, count = 0 after release, bus released.
- STROBE_CYCLES = 3:
  - Stimulus: push 0x9A, then pop.
  - Required: enable high exactly 3 cycles each; response 5 cycles after acceptance; rsp_data = 0x9A.
